// File: rtl/aes_key_expander_if.sv
// ----------------------------------------------------------------------------
// aes_key_expander_if
// Handshake, key input and schedule read-back bundle for aes_key_expander.
// The master side (cipher controller) drives start/key_in/rk_idx; the slave
// side (the expander) returns busy/done/key_valid and the schedule.
// Optional macro KEYEXP_ZEROIZE_EN adds the zeroize request line.
// ----------------------------------------------------------------------------
interface aes_key_expander_if #(
  parameter int KEY_BITS = 128
);
  localparam int NK       = KEY_BITS / 32;
  localparam int NR       = NK + 6;
  localparam int EXP_BITS = 128 * (NR + 1);

  logic                start;
  logic [KEY_BITS-1:0] key_in;
  logic                busy;
  logic                done;
  logic                key_valid;
  logic [3:0]          rk_idx;
  logic [127:0]        round_key;
  logic [EXP_BITS-1:0] expanded_key;

`ifdef KEYEXP_ZEROIZE_EN
  logic                zeroize;

  modport master (
    output start, key_in, rk_idx, zeroize,
    input  busy, done, key_valid, round_key, expanded_key
  );

  modport slave (
    input  start, key_in, rk_idx, zeroize,
    output busy, done, key_valid, round_key, expanded_key
  );
`else
  modport master (
    output start, key_in, rk_idx,
    input  busy, done, key_valid, round_key, expanded_key
  );

  modport slave (
    input  start, key_in, rk_idx,
    output busy, done, key_valid, round_key, expanded_key
  );
`endif
endinterface

// File: rtl/aes_key_expander.sv
// ----------------------------------------------------------------------------
// aes_key_expander
// Iterative AES key schedule for 128/192/256-bit keys. One 32-bit schedule
// word is produced per clock through a single SubWord unit (4 S-box lookups).
// Outputs are gated by key_valid; round_key is an indexed 128-bit read port.
// Optional macro KEYEXP_ZEROIZE_EN adds a zeroize input that wipes all key
// material and aborts any expansion in progress.
// ----------------------------------------------------------------------------
module aes_key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic            clk,
  input  logic            n_rst,
  aes_key_expander_if.slave bus
);

  localparam int NK       = KEY_BITS / 32;
  localparam int NR       = NK + 6;
  localparam int NW       = 4 * (NR + 1);
  localparam int EXP_BITS = 128 * (NR + 1);

  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [5:0] NW_W     = 6'(NW);
  localparam logic [5:0] NW_LAST  = 6'(NW - 1);
  localparam logic [2:0] PH_LAST  = 3'(NK - 1);
  localparam logic [3:0] NR_W     = 4'(NR);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_EXPAND = 1'b1
  } state_t;

  // Byte 'a' sits at bit offset 8*(255-a)+7, i.e. {~a, 3'b111}.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] a);
    return SBOX_TABLE[{~a, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_lookup(w[31:24]), sbox_lookup(w[23:16]),
            sbox_lookup(w[15:8]),  sbox_lookup(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t        state_q, state_d;
  logic [5:0]    i_q, i_d;          // index of the next word to write
  logic [2:0]    ph_q, ph_d;        // i mod NK, tracked incrementally
  logic [7:0]    rcon_q, rcon_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          kv_q, kv_d;
  logic [31:0]   w_q [NW];

  logic          load_s;
  logic          wr_en_s;
  logic          clear_s;
  logic [31:0]   prev_word_s;
  logic [31:0]   back_word_s;
  logic [31:0]   sub_in_s;
  logic [31:0]   sub_out_s;
  logic [31:0]   temp_s;
  logic [31:0]   new_word_s;
  logic [5:0]    rk_base_s;
  logic [127:0]  rk_s;
  logic [EXP_BITS-1:0] flat_s;

  // Fetch w[i-1] and w[i-NK]; indices are clamped so idle reads stay in range.
  always_comb begin
    prev_word_s = 32'h0000_0000;
    back_word_s = 32'h0000_0000;
    if (i_q >= NK_W && i_q < NW_W) begin
      prev_word_s = w_q[i_q - 6'd1];
      back_word_s = w_q[i_q - NK_W];
    end else begin
      prev_word_s = 32'h0000_0000;
      back_word_s = 32'h0000_0000;
    end
  end

  // Word transform: one shared SubWord, fed rotated only on the rcon phase.
  always_comb begin
    sub_in_s  = (ph_q == 3'd0) ? rot_word(prev_word_s) : prev_word_s;
    sub_out_s = sub_word(sub_in_s);
    if (ph_q == 3'd0) begin
      temp_s = sub_out_s ^ {rcon_q, 24'h00_0000};
    end else if (NK == 8 && ph_q == 3'd4) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = prev_word_s;
    end
    new_word_s = back_word_s ^ temp_s;
  end

  // Next-state and handshake logic; zeroize (when present) overrides all.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    ph_d    = ph_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    load_s  = 1'b0;
    wr_en_s = 1'b0;
    clear_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load_s  = 1'b1;
          i_d     = NK_W;
          ph_d    = 3'd0;
          rcon_d  = 8'h01;
          kv_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_EXPAND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXPAND: begin
        wr_en_s = 1'b1;
        i_d     = i_q + 6'd1;
        ph_d    = (ph_q == PH_LAST) ? 3'd0 : ph_q + 3'd1;
        if (ph_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end else begin
          rcon_d = rcon_q;
        end
        if (i_q == NW_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_EXPAND;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        kv_d    = 1'b0;
      end
    endcase
`ifdef KEYEXP_ZEROIZE_EN
    if (bus.zeroize) begin
      clear_s = 1'b1;
      load_s  = 1'b0;
      wr_en_s = 1'b0;
      state_d = S_IDLE;
      i_d     = 6'd0;
      ph_d    = 3'd0;
      rcon_d  = 8'h01;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      kv_d    = 1'b0;
    end else begin
      clear_s = 1'b0;
    end
`endif
  end

  // Control state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      i_q     <= 6'd0;
      ph_q    <= 3'd0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      ph_q    <= ph_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
    end
  end

  // Schedule storage: key load on start, one word per edge while expanding.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NW; k++) w_q[k] <= 32'h0000_0000;
    end else if (clear_s) begin
      for (int k = 0; k < NW; k++) w_q[k] <= 32'h0000_0000;
    end else if (load_s) begin
      for (int k = 0; k < NK; k++) w_q[k] <= bus.key_in[KEY_BITS-1-32*k -: 32];
    end else if (wr_en_s) begin
      w_q[i_q] <= new_word_s;
    end
  end

  // Indexed round-key read, zero when invalid or out of range.
  always_comb begin
    rk_base_s = {bus.rk_idx, 2'b00};
    rk_s      = 128'h0;
    if (kv_q && bus.rk_idx <= NR_W) begin
      rk_s = {w_q[rk_base_s], w_q[rk_base_s + 6'd1],
              w_q[rk_base_s + 6'd2], w_q[rk_base_s + 6'd3]};
    end else begin
      rk_s = 128'h0;
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_flat
    assign flat_s[EXP_BITS-1-32*g -: 32] = w_q[g];
  end

  assign bus.expanded_key = kv_q ? flat_s : {EXP_BITS{1'b0}};
  assign bus.round_key    = rk_s;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.key_valid    = kv_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// ----------------------------------------------------------------------------
// tb_aes_key_expander
// Drives one expander per key length (128/192/256) and compares against a
// behavioural key schedule built from GF(2^8) arithmetic. Covers the
// KEYEXP_ZEROIZE_EN option when that macro is defined.
// ----------------------------------------------------------------------------
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic n_rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] sbox_tab [256];

  always #5 clk = ~clk;

  aes_key_expander_if #(.KEY_BITS(128)) if128 ();
  aes_key_expander_if #(.KEY_BITS(192)) if192 ();
  aes_key_expander_if #(.KEY_BITS(256)) if256 ();

  aes_key_expander #(.KEY_BITS(128)) u128 (.clk(clk), .n_rst(n_rst), .bus(if128));
  aes_key_expander #(.KEY_BITS(192)) u192 (.clk(clk), .n_rst(n_rst), .bus(if192));
  aes_key_expander #(.KEY_BITS(256)) u256 (.clk(clk), .n_rst(n_rst), .bus(if256));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] av  = 8'(a);
      logic [7:0] s;
      if (a == 0) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, av);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[a] = s;
    end
  endtask

  function automatic logic [31:0] ref_subw(input logic [31:0] t);
    return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
  endfunction

  // Full schedule, key left-aligned in 256 bits; result w[0] in MSBs, left-aligned.
  function automatic logic [1919:0] ref_schedule(input int nk, input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] r  = 1920'h0;
    int nw = 4 * (nk + 7);
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = ref_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = ref_subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) r[1919-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic int first_diff(input logic [1919:0] a, input logic [1919:0] b);
    for (int j = 0; j < 60; j++) if (a[1919-32*j -: 32] !== b[1919-32*j -: 32]) return j;
    return 0;
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus / observation helpers ----------------
  task automatic drive(input int sel, input logic s, input logic [255:0] k);
    case (sel)
      0:       begin if128.start = s; if128.key_in = k[255 -: 128]; end
      1:       begin if192.start = s; if192.key_in = k[255 -: 192]; end
      default: begin if256.start = s; if256.key_in = k; end
    endcase
  endtask

  task automatic read_st(input int sel, output logic b, output logic d, output logic v);
    case (sel)
      0:       begin b = if128.busy; d = if128.done; v = if128.key_valid; end
      1:       begin b = if192.busy; d = if192.done; v = if192.key_valid; end
      default: begin b = if256.busy; d = if256.done; v = if256.key_valid; end
    endcase
  endtask

  task automatic read_out(input int sel, input logic [3:0] idx,
                          output logic [127:0] rk, output logic [1919:0] ek);
    if128.rk_idx = idx; if192.rk_idx = idx; if256.rk_idx = idx;
    #1;
    case (sel)
      0:       begin rk = if128.round_key; ek = {if128.expanded_key, 512'h0}; end
      1:       begin rk = if192.round_key; ek = {if192.expanded_key, 256'h0}; end
      default: begin rk = if256.round_key; ek = if256.expanded_key; end
    endcase
  endtask

  // Leaves the caller at #1 after the accepting edge.
  task automatic do_start(input int sel, input logic [255:0] k);
    @(posedge clk); #1;
    drive(sel, 1'b1, k);
    @(posedge clk); #1;
    drive(sel, 1'b0, k);
  endtask

  // Counts edges until done is seen; n = -1 if the bound expires.
  task automatic wait_done(input int sel, output int n);
    logic b, d, v;
    n = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk); #1;
      read_st(sel, b, d, v);
      if (d === 1'b1) begin n = e; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic b, d, v;
    logic [127:0] rk;
    logic [1919:0] ek;
    n_rst = 1'b0;
    #12;
    for (int s = 0; s < 3; s++) begin
      read_st(s, b, d, v);
      n_checks++;
      if ({b, d, v} !== 3'b000) begin
        n_errors++; $display("FAIL reset_flags sel%0d: got %b expected 000", s, {b, d, v});
      end
      read_out(s, 4'd0, rk, ek);
      n_checks++;
      if (rk !== 128'h0 || ek !== 1920'h0) begin
        n_errors++; $display("FAIL reset_outputs sel%0d: got rk %h expected 0", s, rk);
      end
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  task automatic test_known_vectors();
    int n;
    logic b, d, v;
    logic [127:0] rk;
    logic [1919:0] ek, exp_ek;
    logic [255:0] k;
    // FIPS-197 C.1 key, 128-bit
    k = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    do_start(0, k);
    wait_done(0, n);
    n_checks++;
    if (n !== 40) begin n_errors++; $display("FAIL latency128: got %0d expected 40", n); end
    read_st(0, b, d, v);
    n_checks++;
    if ({b, v} !== 2'b01) begin n_errors++; $display("FAIL done_state128: got busy,kv=%b expected 01", {b, v}); end
    @(posedge clk); #1;
    read_st(0, b, d, v);
    n_checks++;
    if ({d, v} !== 2'b01) begin n_errors++; $display("FAIL done_pulse128: got done,kv=%b expected 01", {d, v}); end
    read_out(0, 4'd10, rk, ek);
    n_checks++;
    if (rk !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      n_errors++; $display("FAIL fips128_rk10: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", rk);
    end
    exp_ek = ref_schedule(4, k);
    n_checks++;
    if (ek !== exp_ek) begin
      n_errors++;
      $display("FAIL fips128_ek: word %0d got %h expected %h", first_diff(ek, exp_ek),
               ek[1919-32*first_diff(ek, exp_ek) -: 32], exp_ek[1919-32*first_diff(ek, exp_ek) -: 32]);
    end
    // "Thats my Kung Fu" key
    do_start(0, {128'h5468617473206D79204B756E67204675, 128'h0});
    wait_done(0, n);
    read_out(0, 4'd1, rk, ek);
    n_checks++;
    if (rk !== 128'hE232FCF191129188B159E4E6D679A293) begin
      n_errors++; $display("FAIL kungfu_rk1: got %h expected e232fcf191129188b159e4e6d679a293", rk);
    end
    read_out(0, 4'd10, rk, ek);
    n_checks++;
    if (rk !== 128'h28FDDEF86DA4244ACCC0A4FE3B316F26) begin
      n_errors++; $display("FAIL kungfu_rk10: got %h expected 28fddef86da4244accc0a4fe3b316f26", rk);
    end
    // 192-bit
    k = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    do_start(1, k);
    wait_done(1, n);
    n_checks++;
    if (n !== 46) begin n_errors++; $display("FAIL latency192: got %0d expected 46", n); end
    read_out(1, 4'd12, rk, ek);
    n_checks++;
    if (rk !== 128'ha4970a331a78dc09c418c271e3a41d5d) begin
      n_errors++; $display("FAIL fips192_rk12: got %h expected a4970a331a78dc09c418c271e3a41d5d", rk);
    end
    // 256-bit
    k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    do_start(2, k);
    wait_done(2, n);
    n_checks++;
    if (n !== 52) begin n_errors++; $display("FAIL latency256: got %0d expected 52", n); end
    read_out(2, 4'd14, rk, ek);
    n_checks++;
    if (rk !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
      n_errors++; $display("FAIL fips256_rk14: got %h expected 24fc79ccbf0979e9371ac23c6d68de36", rk);
    end
    exp_ek = ref_schedule(8, k);
    n_checks++;
    if (ek !== exp_ek) begin
      n_errors++; $display("FAIL fips256_ek: word %0d got %h expected %h", first_diff(ek, exp_ek),
               ek[1919-32*first_diff(ek, exp_ek) -: 32], exp_ek[1919-32*first_diff(ek, exp_ek) -: 32]);
    end
  endtask

  task automatic test_rk_range();
    logic [127:0] rk;
    logic [1919:0] ek;
    for (int s = 0; s < 3; s++) begin
      for (int idx = 11 + 2 * s; idx < 16; idx++) begin
        read_out(s, 4'(idx), rk, ek);
        n_checks++;
        if (rk !== 128'h0) begin
          n_errors++; $display("FAIL rk_out_of_range sel%0d idx%0d: got %h expected 0", s, idx, rk);
        end
      end
    end
  endtask

  task automatic test_random_keys();
    int n, nk, nr;
    logic [255:0] k;
    logic [127:0] rk;
    logic [1919:0] ek, exp_ek;
    logic [3:0] idx;
    for (int t = 0; t < 9; t++) begin
      int s = t % 3;
      nk = 4 + 2 * s;
      nr = nk + 6;
      k  = rand_key();
      if (s == 0) k[127:0] = 128'h0;
      if (s == 1) k[63:0]  = 64'h0;
      exp_ek = ref_schedule(nk, k);
      do_start(s, k);
      wait_done(s, n);
      n_checks++;
      if (n !== 4 * (nr + 1) - nk) begin
        n_errors++; $display("FAIL rand_latency sel%0d: got %0d expected %0d", s, n, 4 * (nr + 1) - nk);
      end
      idx = 4'($urandom_range(0, nr));
      read_out(s, idx, rk, ek);
      n_checks++;
      if (rk !== exp_ek[1919-128*idx -: 128]) begin
        n_errors++; $display("FAIL rand_rk sel%0d idx%0d: got %h expected %h", s, idx, rk, exp_ek[1919-128*idx -: 128]);
      end
      n_checks++;
      if (ek !== exp_ek) begin
        n_errors++; $display("FAIL rand_ek sel%0d: word %0d got %h expected %h", s, first_diff(ek, exp_ek),
                 ek[1919-32*first_diff(ek, exp_ek) -: 32], exp_ek[1919-32*first_diff(ek, exp_ek) -: 32]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic b, d, v;
    logic [255:0] ka, kb, kc;
    logic [127:0] rk;
    logic [1919:0] ek, exp_ek;
    ka = {rand_key() >> 128, 128'h0};
    kb = {rand_key() >> 128, 128'h0};
    kc = {rand_key() >> 128, 128'h0};
    // start re-pulsed at edge 5 with another key is ignored
    do_start(0, ka);
    repeat (4) begin @(posedge clk); #1; end
    drive(0, 1'b1, kb);
    @(posedge clk); #1;
    drive(0, 1'b0, kb);
    wait_done(0, n);
    n_checks++;
    if (n + 5 !== 40) begin n_errors++; $display("FAIL busy_start_latency: got %0d expected 40", n + 5); end
    exp_ek = ref_schedule(4, ka);
    read_out(0, 4'd0, rk, ek);
    n_checks++;
    if (ek !== exp_ek) begin
      n_errors++; $display("FAIL busy_start_ignored: word %0d got %h expected %h", first_diff(ek, exp_ek),
               ek[1919-32*first_diff(ek, exp_ek) -: 32], exp_ek[1919-32*first_diff(ek, exp_ek) -: 32]);
    end
    // start in the done cycle is accepted
    do_start(0, kb);
    wait_done(0, n);
    drive(0, 1'b1, kc);
    @(posedge clk); #1;
    drive(0, 1'b0, kc);
    read_st(0, b, d, v);
    n_checks++;
    if ({b, d, v} !== 3'b100) begin
      n_errors++; $display("FAIL start_in_done: got busy,done,kv=%b expected 100", {b, d, v});
    end
    wait_done(0, n);
    n_checks++;
    if (n !== 40) begin n_errors++; $display("FAIL start_in_done_latency: got %0d expected 40", n); end
    exp_ek = ref_schedule(4, kc);
    read_out(0, 4'd0, rk, ek);
    n_checks++;
    if (ek !== exp_ek) begin
      n_errors++; $display("FAIL start_in_done_ek: word %0d got %h expected %h", first_diff(ek, exp_ek),
               ek[1919-32*first_diff(ek, exp_ek) -: 32], exp_ek[1919-32*first_diff(ek, exp_ek) -: 32]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen = 0;
    logic b, d, v;
    logic [255:0] k;
    logic [127:0] rk;
    logic [1919:0] ek, exp_ek;
    do_start(0, rand_key());
    repeat (19) begin @(posedge clk); #1; end
    n_rst = 1'b0;
    read_out(0, 4'd0, rk, ek);
    read_st(0, b, d, v);
    n_checks++;
    if ({b, d, v} !== 3'b000 || rk !== 128'h0 || ek !== 1920'h0) begin
      n_errors++; $display("FAIL reset_mid_outputs: got busy,done,kv=%b rk %h expected 000 and 0", {b, d, v}, rk);
    end
    repeat (2) begin @(posedge clk); #1; end
    n_rst = 1'b1;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      read_st(0, b, d, v);
      if (d === 1'b1 || v === 1'b1 || b === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_errors++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", seen); end
    k = {rand_key() >> 128, 128'h0};
    do_start(0, k);
    wait_done(0, n);
    n_checks++;
    if (n !== 40) begin n_errors++; $display("FAIL after_reset_latency: got %0d expected 40", n); end
    exp_ek = ref_schedule(4, k);
    read_out(0, 4'd0, rk, ek);
    n_checks++;
    if (ek !== exp_ek) begin
      n_errors++; $display("FAIL after_reset_ek: word %0d got %h expected %h", first_diff(ek, exp_ek),
               ek[1919-32*first_diff(ek, exp_ek) -: 32], exp_ek[1919-32*first_diff(ek, exp_ek) -: 32]);
    end
  endtask

`ifdef KEYEXP_ZEROIZE_EN
  task automatic test_zeroize();
    int seen = 0;
    logic b, d, v;
    logic [127:0] rk;
    logic [1919:0] ek;
    do_start(0, rand_key());
    repeat (9) begin @(posedge clk); #1; end
    if128.zeroize = 1'b1;
    @(posedge clk); #1;
    if128.zeroize = 1'b0;
    read_st(0, b, d, v);
    read_out(0, 4'd0, rk, ek);
    n_checks++;
    if ({b, d, v} !== 3'b000 || ek !== 1920'h0) begin
      n_errors++; $display("FAIL zeroize_abort: got busy,done,kv=%b expected 000", {b, d, v});
    end
    for (int e = 0; e < 50; e++) begin
      @(posedge clk); #1;
      read_st(0, b, d, v);
      if (d === 1'b1 || b === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_errors++; $display("FAIL zeroize_no_done: got %0d active cycles expected 0", seen); end
    drive(0, 1'b1, rand_key());
    if128.zeroize = 1'b1;
    @(posedge clk); #1;
    drive(0, 1'b0, 256'h0);
    if128.zeroize = 1'b0;
    seen = 0;
    for (int e = 0; e < 5; e++) begin
      read_st(0, b, d, v);
      if (b === 1'b1 || v === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 0) begin n_errors++; $display("FAIL zeroize_over_start: got %0d active cycles expected 0", seen); end
  endtask
`endif

  initial begin
    n_rst = 1'b0;
    drive(0, 1'b0, 256'h0);
    drive(1, 1'b0, 256'h0);
    drive(2, 1'b0, 256'h0);
    if128.rk_idx = 4'd0; if192.rk_idx = 4'd0; if256.rk_idx = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
    if128.zeroize = 1'b0; if192.zeroize = 1'b0; if256.zeroize = 1'b0;
`endif
    init_sbox();
    test_reset();
    test_known_vectors();
    test_rk_range();
    test_random_keys();
    test_back_to_back();
    test_reset_mid();
`ifdef KEYEXP_ZEROIZE_EN
    test_zeroize();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
